// File: rtl/flex_stp_deser.sv
// flex_stp_deser: parametrised multi-lane serial-to-parallel deserializer.
// Bits are accumulated LANES at a time, and each full word is framed after
// BEATS = NUM_BITS/LANES beats. The completed word goes into a one-word
// output buffer with a valid/ready handshake.
//
// Optional feature (macro FLEX_STP_DESER_PARITY_EN): adds parity_in, which is
// sampled on the completing beat, and a registered parity_err that is updated
// on each buffer load.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   shift_enable  accept serial_in this cycle
//   serial_in     LANES bits per beat; bit LANES-1 is the earlier bit
//   clear         discard the partial word and clear overflow
//   word_ready    consumer accepts parallel_out
//   parallel_out  buffered completed word
//   word_valid    parallel_out holds an unconsumed word
//   overflow      sticky flag: a completed word was dropped
//   beat_count    beats accumulated in the current partial word
module flex_stp_deser #(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned LANES     = 1,
  parameter int unsigned SHIFT_MSB = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    shift_enable,
  input  logic [LANES-1:0]                        serial_in,
  input  logic                                    clear,
  input  logic                                    word_ready,
`ifdef FLEX_STP_DESER_PARITY_EN
  input  logic                                    parity_in,
  output logic                                    parity_err,
`endif
  output logic [NUM_BITS-1:0]                     parallel_out,
  output logic                                    word_valid,
  output logic                                    overflow,
  output logic [$clog2(NUM_BITS/LANES+1)-1:0]     beat_count
);

  localparam int unsigned BEATS = NUM_BITS / LANES;
  localparam int unsigned CW    = $clog2(BEATS + 1);

  logic [NUM_BITS-1:0] sr, sr_d, sr_next, out_d;
  logic [CW-1:0]       cnt_d;
  logic                valid_d, ovf_d;
  logic                shift_ok, complete, consume, load;

  // Next shift-register image; a single-beat word is simply the input beat.
  generate
    if (BEATS == 1) begin : g_one_beat
      assign sr_next = serial_in;
    end else if (SHIFT_MSB != 0) begin : g_msb_first
      assign sr_next = {sr[NUM_BITS-LANES-1:0], serial_in};
    end else begin : g_lsb_first
      assign sr_next = {serial_in, sr[NUM_BITS-1:LANES]};
    end
  endgenerate

  // Clear suppresses capture, so a beat that arrives with clear never completes a word.
  assign shift_ok = shift_enable && !clear;
  assign complete = shift_ok && (beat_count == CW'(BEATS - 1));
  assign consume  = word_valid && word_ready;
  assign load     = complete && (!word_valid || word_ready);

  // Next-state logic for the framing state and the output buffer.
  always_comb begin
    sr_d    = sr;
    cnt_d   = beat_count;
    ovf_d   = overflow;
    valid_d = word_valid;
    out_d   = parallel_out;
    if (clear) begin
      sr_d  = '1;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (shift_enable) begin
      sr_d  = sr_next;
      cnt_d = complete ? '0 : beat_count + CW'(1);
      if (complete && !load) ovf_d = 1'b1;
    end
    if (consume) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      out_d   = sr_next;
    end
  end

  // State registers; the idle line level is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr           <= '1;
      beat_count   <= '0;
      overflow     <= 1'b0;
      word_valid   <= 1'b0;
      parallel_out <= '1;
    end else begin
      sr           <= sr_d;
      beat_count   <= cnt_d;
      overflow     <= ovf_d;
      word_valid   <= valid_d;
      parallel_out <= out_d;
    end
  end

`ifdef FLEX_STP_DESER_PARITY_EN
  // Even parity over word plus parity bit; updated only when a word is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= (^sr_next) != parity_in;
    end
  end
`endif

endmodule

// File: doc/flex_stp_deser.md
Name: flex_stp_deser

Overview:
- Parametrised serial-to-parallel deserializer; successor to the single-lane flex shift register.
- Adds multi-lane input, beat counting and word framing, and a one-word output buffer with valid/ready handshake.
- Adds sticky overflow detection and a synchronous clear of any partial word.
- Sits between line-level receivers (bit samplers, decoders) and byte/word consumers (FIFOs, packet FSMs).

Parameters:
- NUM_BITS, 8, output word width; must be ≥ LANES and an integer multiple of LANES.
- LANES, 1, serial bits accepted per shift beat; BEATS = NUM_BITS/LANES.
- SHIFT_MSB, 1, 1 = new bits enter at LSB and the word fills toward MSB (MSB-first); 0 = new bits enter at MSB and shift toward LSB (LSB-first).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- shift_enable  in  1  accept serial_in this cycle.
- serial_in  in  LANES  serial data; within a beat, bit LANES-1 is the earlier/more significant bit.
- clear  in  1  synchronous discard of partial word and overflow flag.
- word_ready  in  1  consumer accepts parallel_out.
- parallel_out  out  NUM_BITS  buffered completed word.
- word_valid  out  1  parallel_out holds an unconsumed word.
- overflow  out  1  sticky: a completed word was dropped.
- beat_count  out  $clog2(BEATS+1)  beats accumulated in the current partial word.

Behaviour:
- Reset (rst=1 at a clk edge): shift register = all ones (idle line), parallel_out = all ones, word_valid = 0, overflow = 0, beat_count = 0. rst overrides every other input.
- Shift, SHIFT_MSB=1: sr_next = {sr[NUM_BITS-LANES-1:0], serial_in}.
- Shift, SHIFT_MSB=0: sr_next = {serial_in, sr[NUM_BITS-1:LANES]}.
- No shift_enable: shift register and beat_count hold.
- Word completion: shift_enable=1 and beat_count == BEATS-1. On completion beat_count wraps to 0, and the completed word is sr_next. The shift register also loads sr_next; it is not reset.
- Latency: word_valid and the new parallel_out appear on the same edge that captures the final beat. Zero extra cycles.
- Handshake: a word is consumed when word_valid=1 and word_ready=1 at an edge; word_valid then drops unless a new word loads on that edge.
- Buffer load rule: a completed word loads if the buffer is empty, or if the buffer is being consumed on the same edge. In the consumed case word_valid stays 1 with the new data.
- Buffer full, no consume, word completes: the word is dropped, parallel_out is unchanged, and overflow is set to 1 (sticky).
- parallel_out holds its value while word_valid=0; it is never cleared by consumption.
- clear=1: shift register = all ones, beat_count = 0, overflow = 0. The output buffer, word_valid and any handshake on that edge are unaffected.
- clear=1 with shift_enable=1: clear wins; no bits are captured and no word completes.
- BEATS=1 (LANES==NUM_BITS): every enabled beat completes a word; no zero-width slices in the RTL.
- Reset mid-word: the partial word is discarded; the next word starts from beat 0.

Optional Feature:
- Macro: FLEX_STP_DESER_PARITY_EN.
- Defined: adds input parity_in (1 bit), sampled only on the completing beat, and output parity_err (1 bit).
  - parity_err is registered alongside parallel_out, and only on a buffer load.
  - parity_err = 1 when (^completed_word) != parity_in, i.e. even parity over word plus parity bit.
  - Reset value of parity_err is 0; it is unchanged by clear and by dropped words.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
1. Reset. Assert rst for 2 cycles (NUM_BITS=8, LANES=1) -> parallel_out=8'hFF, word_valid=0, overflow=0, beat_count=0.
2. MSB-first word. SHIFT_MSB=1, word_ready=1, serial bits 1,1,0,1,0,0,0,0 on 8 consecutive cycles -> parallel_out=8'hD0, word_valid=1 for exactly one cycle (the cycle after the 8th shift edge), beat_count back to 0.
3. LSB-first and multi-lane words.
   - SHIFT_MSB=0, same bit sequence -> parallel_out=8'h0B.
   - LANES=2, SHIFT_MSB=1, beats 2'b11,2'b00,2'b10,2'b01 -> parallel_out=8'hC9 after 4 beats.
4. Back-pressure and overflow.
   - word_ready=0; shift in 8'h12 then 8'h34 -> parallel_out stays 8'h12, word_valid=1, overflow=1.
   - Then word_ready=1 for one cycle -> word_valid=0.
   - Then clear -> overflow=0.
5. Simultaneous consume and complete. Buffer holds 8'h55; word_ready=1 on the same edge 8'hAA completes -> parallel_out=8'hAA, word_valid stays 1, overflow=0.
6. Clear and reset mid-word.
   - 3 shifts, then clear=1 with shift_enable=1 -> beat_count=0, no word produced. Next 8 bits 8'h3C yield exactly 8'h3C.
   - Repeat using rst mid-word -> same result, parallel_out=8'hFF before the new word.
